// File: rtl/hvtx_ctl.sv
// HDMI TX link bring-up controller: serializer reset sequencing and whole-frame video gating.
// Define HVTX_CTL_WDOG_EN to build the vsync watchdog that re-initialises a stalled link.
module hvtx_ctl #(
  parameter int unsigned LOCK_CYCLES    = 1024,
  parameter int unsigned SER_RST_CYCLES = 16,
  parameter int unsigned WDOG_CYCLES    = 2_000_000,
  parameter logic        SYNC_POL       = 1'b1
) (
  input  logic        i_pclk,
  input  logic        i_rst_n,
  input  logic        i_lock,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [23:0] i_video,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [23:0] o_video,
  output logic        o_ser_rst,
  output logic [1:0]  o_state,
  output logic        o_trip
);

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StSerInit  = 2'd1,
    StSync     = 2'd2,
    StRun      = 2'd3
  } state_e;

  localparam int unsigned LockW = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned SerW  = $clog2(SER_RST_CYCLES + 1);
  localparam logic [LockW-1:0] LockLast = LockW'(LOCK_CYCLES - 1);
  localparam logic [SerW-1:0]  SerLast  = SerW'(SER_RST_CYCLES - 1);

  state_e           state_q, state_d;
  logic             lock_meta_q, lock_sync_q;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
  logic [SerW-1:0]  ser_cnt_q, ser_cnt_d;
  logic             vs_prev_q;
  logic             vs_edge;
  logic             wdog_hit;
  logic             link_cur, link_nxt;
  logic             hs_d, vs_d, de_d, ser_rst_d;
  logic [23:0]      video_d;

  assign vs_edge  = (vs_prev_q != SYNC_POL) && (i_vs == SYNC_POL);
  assign link_cur = (state_q == StSync) || (state_q == StRun);
  assign link_nxt = (state_d == StSync) || (state_d == StRun);

`ifdef HVTX_CTL_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);

  logic [WdogW-1:0] wdog_cnt_q, wdog_cnt_d;

  assign wdog_hit = link_cur && !vs_edge && (wdog_cnt_q == WdogLast);

  // Counts cycles elapsed since the last vsync edge; the edge cycle itself is cycle 0.
  always_comb begin
    wdog_cnt_d = '0;
    if (link_cur && link_nxt) begin
      wdog_cnt_d = vs_edge ? WdogW'(1) : wdog_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (!i_rst_n) begin
      wdog_cnt_q <= '0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_hit    = 1'b0;
`endif

  always_ff @(posedge i_pclk) begin
    if (!i_rst_n) begin
      state_q <= StWaitLock;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitLock: if (lock_sync_q && (lock_cnt_q == LockLast)) state_d = StSerInit;
      StSerInit:  if (ser_cnt_q == SerLast) state_d = StSync;
      StSync:     if (vs_edge) state_d = StRun;
      StRun:      state_d = StRun;
      default:    state_d = StWaitLock;
    endcase
    if (wdog_hit) state_d = StSerInit;
    // Lock loss overrides every other transition, including a watchdog trip.
    if (!lock_sync_q && (state_q != StWaitLock)) state_d = StWaitLock;
  end

  always_comb begin
    lock_cnt_d = '0;
    ser_cnt_d  = '0;
    if ((state_q == StWaitLock) && (state_d == StWaitLock) && lock_sync_q) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
    if ((state_q == StSerInit) && (state_d == StSerInit)) begin
      ser_cnt_d = ser_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (!i_rst_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      lock_cnt_q  <= '0;
      ser_cnt_q   <= '0;
      vs_prev_q   <= ~SYNC_POL;
    end else begin
      lock_meta_q <= i_lock;
      lock_sync_q <= lock_meta_q;
      lock_cnt_q  <= lock_cnt_d;
      ser_cnt_q   <= ser_cnt_d;
      vs_prev_q   <= i_vs;
    end
  end

  // Pass only when the sampled cycle and the next one are both in a passing state, so entry
  // to RUN never leaks a pre-edge pixel and lock loss gates on the same edge it lands.
  always_comb begin
    ser_rst_d = !link_nxt;
    hs_d      = (link_cur && link_nxt) ? i_hs : ~SYNC_POL;
    vs_d      = (link_cur && link_nxt) ? i_vs : ~SYNC_POL;
    de_d      = 1'b0;
    video_d   = '0;
    if ((state_q == StRun) && (state_d == StRun)) begin
      de_d    = i_de;
      video_d = i_video;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (!i_rst_n) begin
      o_hs      <= ~SYNC_POL;
      o_vs      <= ~SYNC_POL;
      o_de      <= 1'b0;
      o_video   <= '0;
      o_ser_rst <= 1'b1;
      o_trip    <= 1'b0;
    end else begin
      o_hs      <= hs_d;
      o_vs      <= vs_d;
      o_de      <= de_d;
      o_video   <= video_d;
      o_ser_rst <= ser_rst_d;
      o_trip    <= wdog_hit;
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_hvtx_ctl.sv
// Bench for hvtx_ctl: bring-up timing, gating, random RUN passthrough, lock loss, mid-frame
// reset and, with HVTX_CTL_WDOG_EN defined, the watchdog trip sequence.
module tb_hvtx_ctl;

  localparam int LockCycles = 16;
  localparam int SerCycles  = 8;
  localparam int WdogCycles = 500;

  logic        pclk = 1'b0;
  logic        rst_n, lock, src_hs, src_vs, src_de;
  logic [23:0] src_video;
  logic        tx_hs, tx_vs, tx_de, ser_rst, trip;
  logic [23:0] tx_video;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  hvtx_ctl #(
    .LOCK_CYCLES   (LockCycles),
    .SER_RST_CYCLES(SerCycles),
    .WDOG_CYCLES   (WdogCycles),
    .SYNC_POL      (1'b1)
  ) dut (
    .i_pclk   (pclk),
    .i_rst_n  (rst_n),
    .i_lock   (lock),
    .i_hs     (src_hs),
    .i_vs     (src_vs),
    .i_de     (src_de),
    .i_video  (src_video),
    .o_hs     (tx_hs),
    .o_vs     (tx_vs),
    .o_de     (tx_de),
    .o_video  (tx_video),
    .o_ser_rst(ser_rst),
    .o_state  (state),
    .o_trip   (trip)
  );

  always #5 pclk = ~pclk;

  // After step() the bench sits 1 time unit past a rising edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_ser_rst"}, 32'(ser_rst), 1);
    check({tag, "_de"}, 32'(tx_de), 0);
    check({tag, "_video"}, 32'(tx_video), 0);
    check({tag, "_hs"}, 32'(tx_hs), 0);
    check({tag, "_vs"}, 32'(tx_vs), 0);
    check({tag, "_trip"}, 32'(trip), 0);
  endtask

  // Raises lock at the current cycle (cycle 0), optionally dropping it for the single cycle
  // 'glitch'; returns on the first SYNC cycle. Requires a settled WAIT_LOCK with lock low.
  task automatic bring_up(input int glitch);
    int t1;
    t1 = (glitch < 0) ? 2 + LockCycles : glitch + 3 + LockCycles;
    for (int c = 0; c <= t1 + SerCycles; c++) begin
      if (c > 0) begin
        check("bring_state", 32'(state), (c < t1) ? 0 : (c < t1 + SerCycles) ? 1 : 2);
        check("bring_ser_rst", 32'(ser_rst), (c < t1 + SerCycles) ? 1 : 0);
        check("bring_de", 32'(tx_de), 0);
      end
      lock = (c == glitch) ? 1'b0 : 1'b1;
      if (c < t1 + SerCycles) step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: summary not reached (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic        exp_hs, exp_vs, exp_de;
    logic [23:0] exp_video;

    rst_n = 1'b0;
    lock = 1'b0;
    src_hs = 1'b0;
    src_vs = 1'b0;
    src_de = 1'b0;
    src_video = '0;
    repeat (3) step();
    check_reset("reset");
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_state", 32'(state), 0);

    bring_up(-1);

    // SYNC: hs/vs follow the source, DE and video stay gated before the first vsync edge.
    src_de = 1'b1;
    src_video = 24'hFFFFFF;
    for (int k = 0; k < 6; k++) begin
      src_hs = 1'($urandom);
      exp_hs = src_hs;
      step();
      check("sync_state", 32'(state), 2);
      check("sync_de", 32'(tx_de), 0);
      check("sync_video", 32'(tx_video), 0);
      check("sync_hs", 32'(tx_hs), 32'(exp_hs));
      check("sync_vs", 32'(tx_vs), 0);
    end

    src_vs = 1'b1;
    step();
    check("run_entry_state", 32'(state), 3);
    check("run_entry_de", 32'(tx_de), 0);
    check("run_entry_vs", 32'(tx_vs), 1);
    exp_video = 24'($urandom);
    src_video = exp_video;
    step();
    check("first_de", 32'(tx_de), 1);
    check("first_video", 32'(tx_video), 32'(exp_video));

    // RUN: every output equals the previous cycle's source values.
    for (int k = 0; k < 200; k++) begin
      src_hs = 1'($urandom);
      src_vs = 1'($urandom);
      src_de = 1'($urandom);
      src_video = 24'($urandom);
      exp_hs = src_hs;
      exp_vs = src_vs;
      exp_de = src_de;
      exp_video = src_video;
      step();
      check("run_state", 32'(state), 3);
      check("run_hs", 32'(tx_hs), 32'(exp_hs));
      check("run_vs", 32'(tx_vs), 32'(exp_vs));
      check("run_de", 32'(tx_de), 32'(exp_de));
      check("run_video", 32'(tx_video), 32'(exp_video));
    end

    // Lock drops at cycle m; gating lands at m+3.
    lock = 1'b0;
    src_vs = 1'b1;
    src_de = 1'b1;
    step();
    check("drop_m1_state", 32'(state), 3);
    step();
    check("drop_m2_state", 32'(state), 3);
    check("drop_m2_de", 32'(tx_de), 1);
    step();
    check("drop_m3_state", 32'(state), 0);
    check("drop_m3_ser_rst", 32'(ser_rst), 1);
    check("drop_m3_vs", 32'(tx_vs), 0);
    check("drop_m3_de", 32'(tx_de), 0);
    check("drop_m3_video", 32'(tx_video), 0);
    src_vs = 1'b0;
    src_de = 1'b0;
    src_hs = 1'b0;
    src_video = '0;
    repeat (3) step();

    bring_up(10);

    src_vs = 1'b1;
    step();
    check("glitch_run_state", 32'(state), 3);
    src_vs = 1'b0;
    src_hs = 1'b1;
    src_de = 1'b1;
    src_video = 24'h5A5A5A;
    step();
    check("pre_reset_de", 32'(tx_de), 1);
    check("pre_reset_video", 32'(tx_video), 32'h5A5A5A);
    rst_n = 1'b0;
    lock = 1'b0;
    step();
    check_reset("midframe_reset");
    rst_n = 1'b1;
    src_hs = 1'b0;
    src_de = 1'b0;
    src_video = '0;
    repeat (3) step();

    bring_up(-1);

    // Last vsync edge sampled at cycle n; i_vs then held low.
    src_vs = 1'b1;
    step();
    check("wdog_run_state", 32'(state), 3);
    src_vs = 1'b0;
    repeat (WdogCycles - 2) step();
    check("wdog_n499_trip", 32'(trip), 0);
    check("wdog_n499_state", 32'(state), 3);
`ifdef HVTX_CTL_WDOG_EN
    step();
    check("wdog_trip", 32'(trip), 1);
    check("wdog_trip_state", 32'(state), 1);
    check("wdog_trip_ser_rst", 32'(ser_rst), 1);
    check("wdog_trip_de", 32'(tx_de), 0);
    for (int c = WdogCycles + 1; c <= WdogCycles + SerCycles; c++) begin
      step();
      check("wdog_after_trip", 32'(trip), 0);
      check("wdog_reinit_state", 32'(state), (c < WdogCycles + SerCycles) ? 1 : 2);
      check("wdog_reinit_ser_rst", 32'(ser_rst), (c < WdogCycles + SerCycles) ? 1 : 0);
    end
`else
    for (int c = WdogCycles; c <= 2000; c++) begin
      step();
      check("nowdog_state", 32'(state), 3);
      check("nowdog_trip", 32'(trip), 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hvtx_ctl.md
# hvtx_ctl

Link bring-up controller for the HDMI transmit path. Sits between the video source and the TMDS encoder/serializer, in the pixel-clock domain. Holds the serializer in reset until the PLL lock is stable, releases it for a fixed settle time, then gates video so the sink sees only whole frames. A lost lock (or, optionally, a stalled frame) triggers a clean re-initialisation.

## Interface
Parameters:
- LOCK_CYCLES, 1024: consecutive synchronised-lock-high cycles required before the serializer is initialised.
- SER_RST_CYCLES, 16: cycles `o_ser_rst` is held in the SER_INIT state.
- WDOG_CYCLES, 2_000_000: maximum cycles between vsync leading edges (watchdog builds only).
- SYNC_POL, 1'b1: active level of hsync/vsync on both input and output.

Ports:
- i_pclk, in, 1: pixel clock; the only clock.
- i_rst_n, in, 1: synchronous, active-low reset.
- i_lock, in, 1: PLL lock, asynchronous; passes through a 2-flop synchroniser internally.
- i_hs, in, 1: source hsync.
- i_vs, in, 1: source vsync.
- i_de, in, 1: source data enable.
- i_video, in, 24: source RGB888 pixel.
- o_hs, out, 1: gated hsync.
- o_vs, out, 1: gated vsync.
- o_de, out, 1: gated data enable.
- o_video, out, 24: gated pixel.
- o_ser_rst, out, 1: active-high serializer reset.
- o_state, out, 2: current state (0 WAIT_LOCK, 1 SER_INIT, 2 SYNC, 3 RUN).
- o_trip, out, 1: one-cycle pulse on watchdog trip; tied to 0 without the watchdog.

## Operation
- Every output is a register.
- Reset values:
  - state WAIT_LOCK; all counters 0; synchroniser 0.
  - o_ser_rst=1; o_de=0; o_video=0.
  - o_hs=o_vs=~SYNC_POL; o_trip=0.
- WAIT_LOCK:
  - o_ser_rst=1; sync outputs inactive; DE and video 0.
  - The lock counter increments on each synchronised-lock-high cycle and clears on any low cycle.
  - On LOCK_CYCLES consecutive high cycles, go to SER_INIT.
- SER_INIT:
  - o_ser_rst=1; outputs as in WAIT_LOCK.
  - After exactly SER_RST_CYCLES cycles, go to SYNC.
- SYNC:
  - o_ser_rst=0; o_hs/o_vs pass through; o_de=0; o_video=0.
  - Go to RUN on a vsync leading edge: the previous sampled i_vs is inactive and the current one equals SYNC_POL.
- RUN:
  - All four video outputs pass through with one cycle of latency.
- Lock loss: a synchronised lock low in SER_INIT, SYNC or RUN goes to WAIT_LOCK on the next cycle and clears all counters. Lock loss has priority over every other transition.
- Counter widths are $clog2(param+1). Counters never wrap: each is cleared on state entry.

## Timing
- Lock path latency: i_lock rising at cycle 0 is seen internally at cycle 2.
  - SER_INIT is entered at cycle 2+LOCK_CYCLES.
  - o_ser_rst falls at cycle 2+LOCK_CYCLES+SER_RST_CYCLES.
- Vsync edge sampled at cycle n → o_state=3 at n+1 → first passed-through DE at n+2 at the earliest.
- Passthrough latency is 1 cycle for hs, vs, de and video, which stay mutually aligned.
- i_lock falling at cycle m → o_state=0, o_ser_rst=1, o_de=0 from cycle m+3.
- Reset asserted mid-frame forces reset values on the next edge, regardless of state.

## Configuration
- `HVTX_CTL_WDOG_EN` defined: a watchdog counter runs in SYNC and RUN.
  - It clears on each vsync leading edge.
  - On reaching WDOG_CYCLES it pulses o_trip for 1 cycle and moves to SER_INIT (serializer reset reasserted, video gated).
  - Lock loss on the same cycle wins: the next state is WAIT_LOCK, and o_trip still pulses.
- Undefined: no watchdog logic is built; o_trip=0 constantly; SYNC and RUN are left only by lock loss or reset.

## Test plan
Bench parameters: LOCK_CYCLES=16, SER_RST_CYCLES=8, WDOG_CYCLES=500, SYNC_POL=1.
- Reset then lock high at cycle 0 → o_state=1 at cycle 18, o_ser_rst falls and o_state=2 at cycle 26, o_de=0 throughout.
- Lock glitch low for 1 cycle at lock-count 10 → counter restarts; SER_INIT entered 16 synchronised-high cycles after the glitch.
- In SYNC, i_de=1 with i_video=24'hFFFFFF before the first vsync → o_de=0, o_video=0. After a vs 0→1 edge at cycle n: o_state=3 at n+1, and i_de=1 at n+1 gives o_de=1 with the matching video at n+2.
- In RUN, drop lock at cycle m → o_state=0, o_ser_rst=1, o_vs=0, o_de=0 at m+3.
- With `HVTX_CTL_WDOG_EN`, hold i_vs=0 in RUN → o_trip pulses exactly 500 cycles after the last vsync edge, followed by o_state=1 and a fresh 8-cycle o_ser_rst.
- Without the macro, the same stimulus for 2000 cycles → o_state stays 3 and o_trip stays 0.
